// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared FSM encoding, default widths and counter sizing for the I2S receive framer
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } i2s_state_t;

    localparam int DATA_W_DEF   = 24;
    localparam int SLOT_MAX_DEF = 32;

    // The bit counter must be able to hold SLOT_MAX+1 so an over-long slot is observable.
    function automatic int cnt_width(input int slot_max);
        return $clog2(slot_max + 2);
    endfunction

endpackage

// File: rtl/i2s_shift_in.sv
// rtl/i2s_shift_in.sv - MSB-first serial capture with saturating bit count and left-aligned word output
module i2s_shift_in
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SLOT_MAX = SLOT_MAX_DEF,
    parameter int CNT_W    = cnt_width(SLOT_MAX)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic              restart_i,
    input  logic              sd_i,
    output logic [DATA_W-1:0] word_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [CNT_W-1:0]  cnt_nxt_o
);

    localparam logic [CNT_W-1:0] DW_C  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(SLOT_MAX + 1);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  pad;

    // Word as it stands including the bit on sd_i now, so a boundary rise sees its own last bit.
    always_comb begin
        sr_nxt  = sr_q;
        if (cnt_q < DW_C) begin
            sr_nxt = {sr_q[DATA_W-2:0], sd_i};
        end
        cnt_nxt = (cnt_q == SAT_C) ? cnt_q : cnt_q + CNT_W'(1);
        pad     = (cnt_nxt >= DW_C) ? '0 : DW_C - cnt_nxt;
        word_o  = sr_nxt << pad;
    end

    // Capture registers; a restart discards the slot just completed after it was read out.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (shift_i) begin
            if (restart_i) begin
                sr_q  <= '0;
                cnt_q <= '0;
            end else begin
                sr_q  <= sr_nxt;
                cnt_q <= cnt_nxt;
            end
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_nxt;

endmodule

// File: rtl/i2s_rx_framer.sv
// rtl/i2s_rx_framer.sv - I2S receive framer FSM, left latch and pair handshake; I2S_RX_OVERRUN_CNT_EN adds overrun_cnt_o
module i2s_rx_framer
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SLOT_MAX = SLOT_MAX_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              sck_rise_i,
    input  logic              ws_i,
    input  logic              sd_i,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              locked_o,
    output logic              overrun_o,
    output logic              slot_err_o
`ifdef I2S_RX_OVERRUN_CNT_EN
    ,
    output logic [7:0]        overrun_cnt_o
`endif
);

    localparam int               CNT_W    = cnt_width(SLOT_MAX);
    localparam logic [CNT_W-1:0] SLOT_LIM = CNT_W'(SLOT_MAX);

    i2s_state_t        state_q;
    i2s_state_t        state_d;
    logic              ws_q;
    logic              boundary;
    logic              in_frame;
    logic              shift;
    logic              err_now;
    logic              left_done;
    logic              pair_load;
    logic              overrun_evt;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] left_lat;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    assign boundary    = sck_rise_i && (ws_i != ws_q);
    assign in_frame    = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
    assign shift       = sck_rise_i && in_frame && en_i;
    assign err_now     = shift && ((boundary && (cnt == '0)) || (cnt_nxt > SLOT_LIM));
    assign left_done   = shift && boundary && !err_now && (state_q == ST_LEFT);
    assign pair_load   = shift && boundary && !err_now && (state_q == ST_RIGHT);
    assign overrun_evt = pair_load && valid_o && !ready_i;
    assign locked_o    = in_frame;

    i2s_shift_in #(
        .DATA_W   (DATA_W),
        .SLOT_MAX (SLOT_MAX),
        .CNT_W    (CNT_W)
    ) u_shift_in (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (!en_i || !in_frame),
        .shift_i   (shift),
        .restart_i (boundary),
        .sd_i      (sd_i),
        .word_o    (word),
        .cnt_o     (cnt),
        .cnt_nxt_o (cnt_nxt)
    );

    // WS history for boundary detection, tracked on every rise regardless of state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ws_q <= 1'b0;
        end else if (sck_rise_i) begin
            ws_q <= ws_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: align on a right-to-left boundary, then alternate until a slot error.
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_HUNT;
                ST_HUNT:  if (boundary && !ws_i) state_d = ST_LEFT;
                ST_LEFT:  if (err_now) state_d = ST_HUNT;
                          else if (left_done) state_d = ST_RIGHT;
                ST_RIGHT: if (err_now) state_d = ST_HUNT;
                          else if (pair_load) state_d = ST_LEFT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Left latch, held pair, valid/ready handshake and the registered event pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            left_lat   <= '0;
            left_o     <= '0;
            right_o    <= '0;
            valid_o    <= 1'b0;
            overrun_o  <= 1'b0;
            slot_err_o <= 1'b0;
        end else begin
            slot_err_o <= err_now;
            overrun_o  <= overrun_evt;
            if (left_done) begin
                left_lat <= word;
            end
            if (pair_load) begin
                left_o  <= left_lat;
                right_o <= word;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;

    // Saturating count of overwritten pairs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            ovr_cnt_q <= 8'd0;
        end else if (overrun_evt && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_framer.sv
// tb/tb_i2s_rx_framer.sv - self-checking bench for i2s_rx_framer
module tb_i2s_rx_framer;
    import i2s_pkg::*;

    localparam int DW = 24;
    localparam int SM = 32;

    logic          clk = 1'b0;
    logic          rst_n, en, sck_rise, ws, sd, ready;
    logic          valid, locked, overrun, slot_err;
    logic [DW-1:0] left, right;
`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [7:0]    ovr_cnt;
`endif

    always #5 clk = ~clk;

    i2s_rx_framer #(.DATA_W(DW), .SLOT_MAX(SM)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .sck_rise_i (sck_rise),
        .ws_i       (ws),
        .sd_i       (sd),
        .left_o     (left),
        .right_o    (right),
        .valid_o    (valid),
        .ready_i    (ready),
        .locked_o   (locked),
        .overrun_o  (overrun),
        .slot_err_o (slot_err)
`ifdef I2S_RX_OVERRUN_CNT_EN
        ,
        .overrun_cnt_o (ovr_cnt)
`endif
    );

    typedef struct {
        bit ch;
        bit sd;
    } bit_t;

    typedef struct {
        logic [31:0] l_tx;
        logic [31:0] r_tx;
        int          n;
        logic [23:0] l_exp;
        logic [23:0] r_exp;
    } vec_t;

    int                tests = 0;
    int                fails = 0;
    int                n_ovr = 0;
    int                n_err = 0;
    bit_t              stream[$];
    logic [2*DW-1:0]   got[$];
    logic [2*DW-1:0]   exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) n_ovr++;
            if (slot_err) n_err++;
            if (valid && ready) got.push_back({left, right});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic append_half(input bit ch, input int n, input logic [31:0] data);
        for (int i = n - 1; i >= 0; i--) begin
            stream.push_back('{ch, (i < 32) ? data[i] : 1'b0});
        end
    endtask

    // WS leads data by one bit: the level on a bit's rise is the channel of the following bit.
    function automatic bit ws_at(input int k);
        return (k + 1 < stream.size()) ? stream[k+1].ch : ~stream[k].ch;
    endfunction

    task automatic play(input int lo, input int hi, input bit ready_last);
        for (int k = lo; k < hi; k++) begin
            @(posedge clk); #1;
            sck_rise = 1'b1;
            sd       = stream[k].sd;
            ws       = ws_at(k);
            if (ready_last && k == hi - 1) ready = 1'b1;
            @(posedge clk); #1;
            sck_rise = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (!valid && c < 2) begin
            @(negedge clk);
            c++;
        end
        chk(name, valid, 1'b1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; sck_rise = 1'b0; ready = 1'b0; ws = 1'b0; sd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stream.delete();
        got.delete();
        n_ovr = 0;
        n_err = 0;
    endtask

    // Reference: collect the bits of each half-frame, judge its length, left-align the first DW bits.
    task automatic model(output int exp_err);
        bit            hunting, ch, wsp, wk, bnd;
        logic [DW-1:0] lw, w;
        bit            q[$];
        hunting = 1'b1; ch = 1'b0; wsp = 1'b0; lw = '0;
        exp_err = 0;
        exp_q.delete();
        for (int k = 0; k < stream.size(); k++) begin
            wk  = ws_at(k);
            bnd = (wk != wsp);
            if (hunting) begin
                if (bnd && !wk) begin
                    hunting = 1'b0;
                    ch      = 1'b0;
                    q.delete();
                end
            end else begin
                q.push_back(stream[k].sd);
                if ((bnd && q.size() == 1) || q.size() > SM) begin
                    exp_err++;
                    hunting = 1'b1;
                end else if (bnd) begin
                    w = '0;
                    for (int i = 0; i < DW && i < q.size(); i++) w[DW-1-i] = q[i];
                    if (!ch) begin
                        lw = w;
                        ch = 1'b1;
                    end else begin
                        exp_q.push_back({lw, w});
                        ch = 1'b0;
                    end
                    q.delete();
                end
            end
            wsp = wk;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int   e1, e3, e4, exp_err, nn, r;

        vt[0] = '{32'hABCDEF5A, 32'h123456C3, 32, 24'hABCDEF, 24'h123456};
        vt[1] = '{32'h0000BEEF, 32'h00001234, 16, 24'hBEEF00, 24'h123400};
        vt[2] = '{32'h00000001, 32'h00FFFFFF, 24, 24'h000001, 24'hFFFFFF};
        vt[3] = '{32'h000000A5, 32'h0000003C,  8, 24'hA50000, 24'h3C0000};
        vt[4] = '{32'h01FFFFFF, 32'h00000001, 25, 24'hFFFFFF, 24'h000000};

        // reset values
        rst_n = 1'b0; en = 1'b1; sck_rise = 1'b0; ready = 1'b0; ws = 1'b0; sd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {valid, locked, overrun, slot_err, left, right}, 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
        chk("reset_ovr_cnt", ovr_cnt, 0);
`endif

        // table-driven frames of various slot widths
        for (int v = 0; v < 5; v++) begin
            do_reset();
            chk("post_reset_locked", locked, 1'b0);
            append_half(1'b1, 4, 32'hF);
            append_half(1'b0, vt[v].n, vt[v].l_tx);
            append_half(1'b1, vt[v].n, vt[v].r_tx);
            play(0, stream.size(), 1'b0);
            wait_valid($sformatf("vec%0d_valid", v));
            chk($sformatf("vec%0d_left", v), left, vt[v].l_exp);
            chk($sformatf("vec%0d_right", v), right, vt[v].r_exp);
            chk($sformatf("vec%0d_locked", v), locked, 1'b1);
            chk($sformatf("vec%0d_no_err", v), n_err, 0);
        end

        // two pairs without acceptance: one overrun, second pair held
        do_reset();
        append_half(1'b1, 4, 32'h5);
        append_half(1'b0, 32, 32'h11111111);
        append_half(1'b1, 32, 32'h22222222);
        append_half(1'b0, 32, 32'hABCDEF01);
        append_half(1'b1, 32, 32'h12345602);
        play(0, stream.size(), 1'b0);
        wait_valid("ovr_valid");
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_left", left, 24'hABCDEF);
        chk("ovr_right", right, 24'h123456);
`ifdef I2S_RX_OVERRUN_CNT_EN
        chk("ovr_cnt", ovr_cnt, 1);
`endif

        // load coincident with handshake: no overrun, new pair next cycle
        do_reset();
        append_half(1'b1, 4, 32'h0);
        append_half(1'b0, 24, 32'h010203);
        append_half(1'b1, 24, 32'h040506);
        append_half(1'b0, 24, 32'hA1B2C3);
        append_half(1'b1, 24, 32'hD4E5F6);
        play(0, stream.size(), 1'b1);
        wait_valid("coin_valid");
        chk("coin_left", left, 24'hA1B2C3);
        chk("coin_right", right, 24'hD4E5F6);
        chk("coin_no_ovr", n_ovr, 0);
        chk("coin_hs_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("coin_hs0", got[0], {24'h010203, 24'h040506});
            chk("coin_hs1", got[1], {24'hA1B2C3, 24'hD4E5F6});
        end
        @(negedge clk);
        chk("coin_valid_clear", valid, 1'b0);

        // WS stuck for 40 rises: slot error, hunt, then realign
        do_reset();
        ready = 1'b1;
        append_half(1'b1, 4, 32'h3);
        append_half(1'b0, 40, 32'hFFFF0000);
        play(0, stream.size(), 1'b0);
        @(negedge clk); #1;
        chk("stuck_err", n_err, 1);
        chk("stuck_locked", locked, 1'b0);
        e1 = stream.size();
        append_half(1'b1, 8, 32'h81);
        append_half(1'b0, 24, 32'h5A5A5A);
        append_half(1'b1, 24, 32'hC0FFEE);
        play(e1, stream.size(), 1'b0);
        wait_valid("realign_valid");
        chk("realign_left", left, 24'h5A5A5A);
        chk("realign_right", right, 24'hC0FFEE);
        chk("realign_err", n_err, 1);

        // reset (mode 0) or disable (mode 1) in the middle of a left slot
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            append_half(1'b1, 4, 32'h9);
            append_half(1'b0, 24, 32'h111111);
            append_half(1'b1, 24, 32'h222222);
            e1 = stream.size();
            append_half(1'b0, 24, 32'h333333);
            append_half(1'b1, 24, 32'h444444);
            e3 = stream.size();
            append_half(1'b0, 24, 32'h3C5A96);
            append_half(1'b1, 24, 32'h0F1E2D);
            e4 = stream.size();
            play(0, e1, 1'b0);
            wait_valid($sformatf("mid%0d_pre_valid", mode));
            play(e1, e1 + 10, 1'b0);
            if (mode == 0) rst_n = 1'b0; else en = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("mid%0d_zero", mode), {valid, locked, overrun, slot_err, left, right}, 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
            chk($sformatf("mid%0d_zero_cnt", mode), ovr_cnt, 0);
`endif
            rst_n = 1'b1; en = 1'b1;
            play(e1 + 10, e3, 1'b0);
            repeat (4) @(negedge clk);
            chk($sformatf("mid%0d_no_valid", mode), valid, 1'b0);
            play(e3, e4, 1'b0);
            wait_valid($sformatf("mid%0d_valid", mode));
            chk($sformatf("mid%0d_left", mode), left, 24'h3C5A96);
            chk($sformatf("mid%0d_right", mode), right, 24'h0F1E2D);
            chk($sformatf("mid%0d_no_ovr", mode), n_ovr, 0);
        end

        // randomized slot lengths and data against the reference model
        do_reset();
        ready = 1'b1;
        append_half(1'b1, 5, 32'h15);
        for (int f = 0; f < 30; f++) begin
            for (int c = 0; c < 2; c++) begin
                r = $urandom_range(0, 19);
                if (r == 0) nn = 1;
                else if (r == 1) nn = $urandom_range(33, 40);
                else nn = $urandom_range(8, 32);
                append_half(c[0], nn, $urandom);
            end
        end
        model(exp_err);
        play(0, stream.size(), 1'b0);
        repeat (4) @(negedge clk);
        #1;
        chk("rand_pair_count", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("rand_pair%0d", i), got[i], exp_q[i]);
        end
        chk("rand_slot_err", n_err, exp_err);
        chk("rand_no_ovr", n_ovr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
